// File: rtl/audio_pkg.sv
// Shared types and helpers for the PWM audio output stage.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } pwm_state_t;

    // Left shift by 0..7; anything spilling past bit 15 saturates to full scale.
    function automatic logic [SAMPLE_W-1:0] sat_shl16(input logic [SAMPLE_W-1:0] s,
                                                      input logic [2:0]          sh);
        logic [SAMPLE_W+6:0] g;
        g = {7'd0, s} << sh;
        return (|g[SAMPLE_W+6:SAMPLE_W]) ? '1 : g[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// Mixer-side bus of the PWM audio output stage: control/sample inputs, pin and status outputs.
interface audio_pwm_out_if #(
    parameter int FIFO_DEPTH = 4
);
    import audio_pkg::*;

    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                enable;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic [2:0]          gain_shift;
    logic                clear_flags;
    logic                pwm_out;
    logic                aud_sd;
    logic [LEVEL_W-1:0]  fifo_level;
    logic                overflow;
    logic                underrun;

    modport master (
        output enable, sample_in, sample_valid, gain_shift, clear_flags,
        input  pwm_out, aud_sd, fifo_level, overflow, underrun
    );

    modport slave (
        input  enable, sample_in, sample_valid, gain_shift, clear_flags,
        output pwm_out, aud_sd, fifo_level, overflow, underrun
    );

endinterface

// File: rtl/audio_pwm_out_sample_fifo.sv
// Small synchronous sample FIFO with flush; push while full succeeds only alongside a pop.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and level decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign level = level_q;

endmodule

// File: rtl/audio_pwm_out.sv
// PWM audio output stage: sample FIFO, IDLE/PRIME/RUN sequencer, saturating gain, frame comparator.
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int PWM_BITS   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    audio_pwm_out_if.slave  bus
);
    localparam int                  LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    pwm_state_t          state_q, state_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;
    logic                overflow_q, overflow_d;
    logic                underrun_q, underrun_d;

    logic                flush, push, pop, running;
    logic                full, empty;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic [LEVEL_W-1:0]  level;
    logic [PWM_BITS-1:0] duty_new;

    assign flush    = (state_q == IDLE) || !bus.enable;
    assign push     = bus.sample_valid && !flush;
    assign running  = (state_q == RUN) && bus.enable;
    assign pop      = running && (cnt_q == CNT_MAX);
    assign duty_new = PWM_BITS'(sat_shl16(fifo_dout, bus.gain_shift) >> (SAMPLE_W - PWM_BITS));

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (bus.sample_in),
        .dout  (fifo_dout),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // NOTE: every _d gets a default before any branch so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        duty_d  = duty_q;
        pwm_d   = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            duty_d  = '0;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (level >= LEVEL_W'(2)) state_d = RUN;
                RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    pwm_d = (cnt_q < duty_q);
                    if (pop && !empty) duty_d = duty_new;
                end
                default: state_d = IDLE;
            endcase
        end

        // A new set event wins over clear_flags in the same cycle.
        overflow_d = bus.clear_flags ? 1'b0 : overflow_q;
        underrun_d = bus.clear_flags ? 1'b0 : underrun_q;
        if (push && full && !pop) overflow_d = 1'b1;
        if (pop && empty)         underrun_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.aud_sd     = (state_q != IDLE);
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: doc/audio_pwm_out.md
# audio_pwm_out

Output stage downstream of the chord mixer: accepts one 16-bit unsigned mixed sample per audio strobe, buffers it in a small FIFO, applies a saturating power-of-two gain, and drives a single-bit PWM audio pin plus amplifier enable. Decouples the mixer's sample strobe from the PWM frame boundary and flags overflow and underrun for the control registers.

## Interface
- PWM_BITS, 10, duty resolution; frame length 2^PWM_BITS clk cycles (1024 at 100 MHz gives ≈97.7 kHz)
- FIFO_DEPTH, 4, sample FIFO entries (power of two, ≥2)
- clk  in  1  system clock; one clock domain only
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = play; 0 = return to IDLE and flush the FIFO
- sample_in  in  16  unsigned mixed sample
- sample_valid  in  1  one-clk strobe; sample_in is valid in that cycle
- gain_shift  in  3  left-shift 0..7 applied before truncation, saturating
- clear_flags  in  1  clears sticky flags
- pwm_out  out  1  PWM audio pin
- aud_sd  out  1  amplifier enable, 1 in PRIME and RUN
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; a sample was dropped
- underrun  out  1  sticky; a frame started with the FIFO empty

## Operation
- FSM states: IDLE, PRIME, RUN. Reset → IDLE.
- IDLE: pwm_out=0, aud_sd=0, FIFO held empty, pushes ignored. enable=1 → PRIME.
- PRIME: pushes accepted; aud_sd=1; pwm_out=0. fifo_level≥2 → RUN; the frame counter restarts at 0 on entry to RUN.
- RUN: frame counter cnt counts 0..2^PWM_BITS−1 and wraps. When cnt==max, pop one sample and compute duty; the new duty takes effect at cnt=0.
- Duty computation: g = sample << gain_shift, computed in 23 bits. If any bit above bit 15 is set, g = 16'hFFFF. duty = g[15:16−PWM_BITS].
- pwm_out = (cnt < duty), registered.
- enable=0 in any state → IDLE at the next edge, FIFO flushed, and duty cleared to 0.
- Push when full with no pop in the same cycle: drop the sample and set overflow.
- Push and pop in the same cycle while full: both succeed and the level is unchanged.
- Pop when empty (RUN, cnt==max): duty holds its previous value and underrun is set. A push in the same cycle is stored and is not bypassed.
- clear_flags has lower priority than a new set event in the same cycle.

## Timing
- Reset values: pwm_out=0, aud_sd=0, fifo_level=0, overflow=0, underrun=0, duty=0, cnt=0, state=IDLE.
- Push: fifo_level updates 1 cycle after the sample_valid edge.
- Latency: a sample popped at cnt==max first appears on pwm_out in the cycle after cnt=0. The pwm_out register adds 1 cycle.
- Pulse width: duty=0 gives pwm_out low for the whole frame. duty=2^PWM_BITS−1 gives pwm_out high for 2^PWM_BITS−1 cycles per frame.
- Flags: set 1 cycle after the causing event and stay set until clear_flags or rst.
- Reset mid-frame: all state returns to reset values at the next edge, and any pulse in progress is truncated.

## Structure
- Shared package audio_pkg holds:
  - the state enum pwm_state_t (IDLE, PRIME, RUN)
  - constant SAMPLE_W=16
  - the saturating-shift function sat_shl16
- One sub-module, sample_fifo: synchronous FIFO with parameters DEPTH and WIDTH, ports push/pop/din/dout/level/full/empty, and a flush input. The FSM, frame counter, gain logic and comparator stay in the top level.

## Test plan
- Reset and idle: assert rst for 3 cycles with enable=0 and pulse sample_valid → all outputs 0, fifo_level stays 0.
- Prime and play: enable=1, push 16'h8000 then 16'h4000 with gain_shift=0 → RUN entered when level=2. First frame high for 512 cycles, second frame high for 256 cycles.
- Saturation: push 16'h2000 with gain_shift=3 → duty=1023, pwm_out high for 1023 of 1024 cycles. Push 16'h1000 with gain_shift=2 → duty=256.
- Overflow: in PRIME, push 5 samples with no pop → fifo_level=4, overflow=1. clear_flags → overflow=0 next cycle.
- Underrun: in RUN, stop pushes until the FIFO is empty → underrun=1 and the previous duty is repeated for the following frame. A push coinciding with the empty pop gives fifo_level=1.
- Simultaneous events: FIFO full, push at cnt==max → level stays 4 and no overflow. Deassert enable mid-frame → pwm_out=0 and aud_sd=0 next cycle, fifo_level=0.
